// File: rtl/kong_pkg.sv
// Shared encodings and sprite defaults for the Kong controller.
// The game-state and animation encodings are visible on the top-level ports.
package kong_pkg;

  typedef enum logic [1:0] {
    ST_INITIAL = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_OVER    = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    AN_NORMAL = 2'd0,
    AN_GET    = 2'd1,
    AN_HOLD   = 2'd2,
    AN_DROP   = 2'd3
  } anim_e;

  localparam int X_POS_DEF = 150;
  localparam int Y_POS_DEF = 150;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic anim_e next_anim(input anim_e a);
    case (a)
      AN_NORMAL: return AN_GET;
      AN_GET:    return AN_HOLD;
      AN_HOLD:   return AN_DROP;
      default:   return AN_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/kong_tick_div.sv
// Frame-tick prescaler: emits a one-cycle step on every TICK_DIV-th enabled tick.
// step_o is combinational so the sequencer acts on the same edge as the wrap.
module kong_tick_div #(
  parameter int TICK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  input  logic tick_i,
  output logic step_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap   = (cnt_q == LAST);
  assign step_o = en_i && tick_i && wrap;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && tick_i) begin
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/kong_sequencer.sv
// Kong controller: game-state FSM, throw-animation sequencer paced by frame ticks,
// timed game-over hold and the barrel-spawn request/acknowledge handshake.
module kong_sequencer
  import kong_pkg::*;
#(
  parameter int X_POS      = X_POS_DEF,
  parameter int Y_POS      = Y_POS_DEF,
  parameter int TICK_DIV   = 2,
  parameter int NORMAL_LEN = 5,
  parameter int GET_LEN    = 1,
  parameter int HOLD_LEN   = 1,
  parameter int DROP_LEN   = 1,
  parameter int OVER_TICKS = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       over,
  input  logic       barrels_full,
  input  logic       barrel_ack,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [1:0] state,
  output logic [1:0] animation_state,
  output logic       barrel_req,
  output logic [7:0] throw_count
);

  localparam int MAX_LEN = max4(NORMAL_LEN, GET_LEN, HOLD_LEN, DROP_LEN);
  localparam int SW      = $clog2(MAX_LEN + 1);
  localparam int OW      = $clog2(OVER_TICKS + 1);
  localparam logic [OW-1:0] OVER_LAST = OW'(OVER_TICKS - 1);

  game_state_e   state_q;
  anim_e         anim_q;
  logic [SW-1:0] step_q;
  logic [OW-1:0] over_q;
  logic          req_q;
  logic [7:0]    throws_q;
  logic [7:0]    throws_d;
  logic [9:0]    x_q;
  logic [8:0]    y_q;

  logic          start_play;
  logic          play_en;
  logic          step;
  logic          phase_done;
  logic          ack_take;
  logic [SW-1:0] last_step;

  function automatic logic [SW-1:0] last_of(input anim_e a);
    case (a)
      AN_NORMAL: return SW'(NORMAL_LEN - 1);
      AN_GET:    return SW'(GET_LEN - 1);
      AN_HOLD:   return SW'(HOLD_LEN - 1);
      default:   return SW'(DROP_LEN - 1);
    endcase
  endfunction

  // Play only advances on edges where neither pause nor over is asserted.
  assign start_play = (state_q == ST_INITIAL) && start;
  assign play_en    = (state_q == ST_PLAYING) && !over && !pause;
  assign last_step  = last_of(anim_q);
  assign phase_done = step && (step_q == last_step);
  assign ack_take   = req_q && barrel_ack;
  assign throws_d   = (throws_q == 8'hFF) ? throws_q : throws_q + 8'd1;

  kong_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (start_play),
    .en_i   (play_en),
    .tick_i (tick),
    .step_o (step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_INITIAL;
      anim_q   <= AN_NORMAL;
      step_q   <= '0;
      over_q   <= '0;
      req_q    <= 1'b0;
      throws_q <= '0;
      x_q      <= 10'(X_POS);
      y_q      <= 9'(Y_POS);
    end else begin
      x_q <= 10'(X_POS);
      y_q <= 9'(Y_POS);

      // The handshake is serviced in every state, including PAUSED.
      if (ack_take) begin
        req_q    <= 1'b0;
        throws_q <= throws_d;
      end

      case (state_q)
        ST_INITIAL: begin
          if (start) begin
            state_q  <= ST_PLAYING;
            anim_q   <= AN_NORMAL;
            step_q   <= '0;
            req_q    <= 1'b0;
            throws_q <= '0;
          end
        end

        ST_PLAYING: begin
          if (over) begin
            state_q <= ST_OVER;
            anim_q  <= AN_NORMAL;
            step_q  <= '0;
            req_q   <= 1'b0;
            over_q  <= '0;
          end else if (pause) begin
            state_q <= ST_PAUSED;
          end else if (step) begin
            if (!phase_done) begin
              step_q <= step_q + SW'(1);
            end else begin
              // Gated phases keep the counter parked on the last step so every
              // later step re-evaluates the gate.
              case (anim_q)
                AN_HOLD: begin
                  if (!barrels_full) begin
                    anim_q <= AN_DROP;
                    step_q <= '0;
                    req_q  <= 1'b1;
                  end
                end
                AN_DROP: begin
                  if (!req_q) begin
                    anim_q <= AN_NORMAL;
                    step_q <= '0;
                  end
                end
                default: begin
                  anim_q <= next_anim(anim_q);
                  step_q <= '0;
                end
              endcase
            end
          end
        end

        ST_PAUSED: begin
          if (over) begin
            state_q <= ST_OVER;
            anim_q  <= AN_NORMAL;
            step_q  <= '0;
            req_q   <= 1'b0;
            over_q  <= '0;
          end else if (!pause) begin
            state_q <= ST_PLAYING;
          end
        end

        default: begin
          if (tick) begin
            if (over_q == OVER_LAST) begin
              state_q <= ST_INITIAL;
              over_q  <= '0;
            end else begin
              over_q <= over_q + OW'(1);
            end
          end
        end
      endcase
    end
  end

  assign x               = x_q;
  assign y               = y_q;
  assign state           = state_q;
  assign animation_state = anim_q;
  assign barrel_req      = req_q;
  assign throw_count     = throws_q;

endmodule

// File: doc/kong_sequencer.md
Name: kong_sequencer

Overview:
Parametrised Kong controller: game-state FSM plus a configurable throw-animation sequencer that paces on an external frame tick. Adds pause, a timed game-over hold, and a barrel-spawn request/acknowledge handshake to the barrel spawner. Sits between the top-level game FSM (start/over/pause) and the sprite renderer and barrel spawner.

Parameters:
X_POS, 150, sprite x position (10 bit)
Y_POS, 150, sprite y position (9 bit)
TICK_DIV, 2, tick pulses per animation step (>=1)
NORMAL_LEN, 5, steps spent in NORMAL (>=1)
GET_LEN, 1, steps spent in GET (>=1)
HOLD_LEN, 1, minimum steps spent in HOLD (>=1)
DROP_LEN, 1, minimum steps spent in DROP (>=1)
OVER_TICKS, 120, tick pulses held in OVER before returning to INITIAL (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
tick  in  1  one-cycle frame-tick enable
start  in  1  start request
pause  in  1  level; high freezes play
over  in  1  game-over request
barrels_full  in  1  spawner cannot accept another barrel
barrel_ack  in  1  spawner accepted the request
x  out  10  X_POS constant
y  out  9  Y_POS constant
state  out  2  INITIAL=0, PLAYING=1, PAUSED=2, OVER=3
animation_state  out  2  NORMAL=0, GET=1, HOLD=2, DROP=3
barrel_req  out  1  spawn request
throw_count  out  8  barrels released this game, saturating

Behaviour:
- All outputs are registered. rst low asynchronously forces: state=INITIAL, animation_state=NORMAL, barrel_req=0, throw_count=0, and the prescaler, step counter and over counter to 0.
- Game FSM, evaluated per clk edge:
  - INITIAL: start -> PLAYING. Entering PLAYING clears the prescaler, step counter and throw_count, and sets animation_state=NORMAL. over and pause are ignored in INITIAL.
  - PLAYING: over -> OVER; else pause -> PAUSED. over has priority over pause.
  - PAUSED: over -> OVER; else pause low -> PLAYING. All counters, animation_state and barrel_req are frozen; ack handling stays active.
  - OVER: animation_state forced NORMAL and barrel_req cleared on entry; any outstanding request is abandoned. Counts tick pulses; on tick number OVER_TICKS -> INITIAL. start is ignored in OVER.
- Prescaler: counts tick only in PLAYING. The tick that makes it reach TICK_DIV-1 wraps it to 0 and produces an animation step the same cycle.
- Animation sequencer: on each step, the step counter increments. When it reaches the current phase length, the phase advances and the counter clears. Order is NORMAL -> GET -> HOLD -> DROP -> NORMAL.
- HOLD->DROP is gated. If barrels_full=1 at the advancing step, Kong stays in HOLD and re-checks every step.
- Entering DROP sets barrel_req=1 on the same edge. barrel_req stays high until barrel_ack=1 is sampled, then clears on the next edge.
- On the acked edge, throw_count increments, saturating at 255.
- DROP->NORMAL is gated. The phase does not advance while barrel_req=1; the step counter holds at DROP_LEN-1 until the ack.
- barrel_ack while barrel_req=0 is ignored.
- Default parameters with tick tied high reproduce a 16-clk cycle: NORMAL 10, GET 2, HOLD 2, DROP 2.
- Counter widths are derived with $clog2 of the largest length; no wrap occurs inside a phase.

Decomposition:
- Shared package/header kong_pkg holds the state and animation encodings and sprite position defaults.
- One sub-module, kong_tick_div: parametrised prescaler with clear and enable, producing the step pulse.

Test Plan:
1. Reset mid-DROP with barrel_req=1 (rst low 1 clk) -> all outputs reset at once: state=0, anim=0, barrel_req=0, throw_count=0.
2. Defaults, tick=1, start pulse, ack returned 1 clk after req -> anim NORMAL for 10 clk, GET 2, HOLD 2, DROP 2; barrel_req high 1 clk; throw_count=1 after the first cycle.
3. barrels_full=1 during HOLD for 8 clk -> anim stays HOLD for 10 clk total; DROP and barrel_req only after full drops.
4. Ack withheld 20 clk -> barrel_req and DROP held 20 clk, throw_count unchanged; ack -> req clears next edge, NORMAL follows.
5. pause=1 for 7 clk mid-GET, then over and pause together -> anim and counters frozen during pause; simultaneous over gives state=OVER, anim=NORMAL, req=0; with OVER_TICKS=3 and tick every clk, INITIAL after 3 clk.
6. 256 acked throws -> throw_count saturates at 255; start with over=1 in INITIAL -> PLAYING.
